load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-side producer of Read_Data for the datapath writeback select.
- Accepts load/store requests from the core (address = ALU result), runs a valid/ready transaction to word-wide data memory, and stalls the core while the transaction is pending.
- Applies byte/halfword lane selection, sign/zero extension and byte enables.
- Flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 16, max cycles in ACCESS waiting for mem_ready before bus error (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
MemRead  input  1  load request; held stable by core while Stall=1
MemWrite  input  1  store request; MemRead and MemWrite both high is treated as load
Funct3  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use [1:0] only (00 SB, 01 SH, 10 SW)
Address  input  32  byte address (ALU result)
Write_Data  input  32  store data (low lanes significant)
Read_Data  output  32  formatted load result
Stall  output  1  core must hold PC and inputs
Misaligned  output  1  one-cycle pulse, misaligned access rejected
Bus_Error  output  1  one-cycle pulse, transaction timed out
mem_req  output  1  memory request valid
mem_we  output  1  1 = write
mem_addr  output  32  {Address[31:2],2'b00}
mem_be  output  4  byte enables (write only; 0000 on reads)
mem_wdata  output  32  lane-replicated store data
mem_ready  input  1  memory accepts/completes the request this cycle
mem_rdata  input  32  read word, valid when mem_ready=1 on a read

Behaviour:
- States: IDLE, ACCESS, DONE. Reset value is IDLE.
- Output reset values: Read_Data=0, Stall=0, Misaligned=0, Bus_Error=0, mem_req=0, mem_we=0, mem_be=0. mem_addr and mem_wdata are don't-care when mem_req=0; drive 0 in the implementation.
- IDLE:
  - Stall = MemRead|MemWrite (combinational), so the core stalls in the request cycle.
  - Misalignment rules: halfword with Address[0]=1 is misaligned; word with Address[1:0]!=0 is misaligned; a byte access is never misaligned.
  - Misaligned request: no memory request; next state DONE with Misaligned=1 pulse in DONE. Read_Data is unchanged for stores and set to 0 for loads.
  - Aligned request: latch address, Funct3, data and direction; next state ACCESS with timeout counter=0.
- ACCESS:
  - mem_req=1, Stall=1. mem_we, mem_addr, mem_be and mem_wdata come from latched values and are stable until mem_ready.
  - mem_ready=1: for a load, capture the formatted mem_rdata into Read_Data; go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without ready, go to DONE with Bus_Error=1 pulse in DONE, Read_Data=0 for loads.
- DONE:
  - Stall=0 and mem_req=0; the core advances on this edge.
  - Next state is IDLE unconditionally. A back-to-back request is seen in the following IDLE cycle.
- Load formatting:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Funct3 011/110/111 on a load is treated as LW.
- Store formatting:
  - SB: wdata = {4{WD[7:0]}}, be = 0001<<addr[1:0].
  - SH: wdata = {2{WD[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: wdata = WD, be = 1111.
- Latency: an aligned access with immediate ready gives Stall high for 2 cycles (IDLE, ACCESS) and the result in DONE.
- Read_Data holds its value between loads. Stores never modify it except as noted above.
- reset asserted in any state: IDLE next edge, all outputs to reset values, in-flight mem_req dropped.

Test Plan:
- Reset mid-ACCESS (mem_ready held 0) -> next cycle mem_req=0, Stall=0, Read_Data=0, state IDLE.
- LB from Address=0x1003, memory word 0x80FF7F01, mem_ready on the first ACCESS cycle:
  - Required: Stall=1 for 2 cycles, mem_addr=0x1000, mem_be=0000.
  - Required: Read_Data=0xFFFFFF80 in DONE; repeating the access as LBU gives 0x00000080.
- SH at Address=0x2002, Write_Data=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x2000; Read_Data unchanged.
- LW at Address=0x3001 -> no mem_req; Misaligned=1 for exactly one cycle; Read_Data=0; Stall low in DONE.
- LW with mem_ready delayed 3 cycles, TIMEOUT=16, mem_rdata=0xDEADBEEF:
  - Required: Stall high 5 cycles, Read_Data=0xDEADBEEF, Bus_Error=0.
  - With mem_ready never asserted: Bus_Error pulses after 16 ACCESS cycles and the core is released.
- Back-to-back SW then LW (MemWrite→MemRead with no idle gap) -> two separate transactions, each with a DONE cycle between, no overlap of mem_req.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: runs one valid/ready word transaction per core request, formats
// load data into Read_Data, and reports misaligned accesses and bus timeouts.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Address,
    input  logic [31:0] Write_Data,
    output logic [31:0] Read_Data,
    output logic        Stall,
    output logic        Misaligned,
    output logic        Bus_Error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);
    // Memory handshake: mem_req stays high with stable mem_we/addr/be/wdata until the
    // cycle in which mem_ready=1; that cycle both accepts and completes the transfer.

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_be;
    logic [2:0]    lat_f3;
    logic          lat_load;

    logic          req;
    logic          is_load;
    logic          misaligned;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [31:0]   ld_data;

    function automatic logic [31:0] format_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign req     = MemRead | MemWrite;
    assign is_load = MemRead;

    // Funct3[1:0] encodes size for both loads and stores (11 behaves as a word).
    always_comb begin
        misaligned = 1'b0;
        st_be      = 4'b1111;
        st_wdata   = Write_Data;
        case (Funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << Address[1:0];
                st_wdata = {4{Write_Data[7:0]}};
            end
            2'b01: begin
                misaligned = Address[0];
                st_be      = Address[1] ? 4'b1100 : 4'b0011;
                st_wdata   = {2{Write_Data[15:0]}};
            end
            default: misaligned = |Address[1:0];
        endcase
    end

    assign ld_data = format_load(mem_rdata, lat_addr[1:0], lat_f3);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            lat_f3     <= '0;
            lat_load   <= 1'b0;
            Read_Data  <= '0;
            Misaligned <= 1'b0;
            Bus_Error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (misaligned) begin
                            state      <= DONE;
                            Misaligned <= 1'b1;
                            if (is_load) Read_Data <= '0;
                        end else begin
                            state     <= ACCESS;
                            cnt       <= '0;
                            lat_addr  <= Address;
                            lat_f3    <= Funct3;
                            lat_load  <= is_load;
                            lat_be    <= st_be;
                            lat_wdata <= st_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        state <= DONE;
                        if (lat_load) Read_Data <= ld_data;
                    end else if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        Bus_Error <= 1'b1;
                        if (lat_load) Read_Data <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    Misaligned <= 1'b0;
                    Bus_Error  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req   = (state == ACCESS);
        Stall     = mem_req | ((state == IDLE) & req);
        mem_we    = mem_req & ~lat_load;
        mem_addr  = mem_req ? {lat_addr[31:2], 2'b00} : 32'd0;
        mem_be    = mem_we ? lat_be : 4'd0;
        mem_wdata = mem_we ? lat_wdata : 32'd0;
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases followed by random transactions, each
// checked against a transaction-level model of the access rules.
module tb_load_store_unit;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Address, Write_Data;
    logic [31:0] Read_Data;
    logic        Stall, Misaligned, Bus_Error;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_rd;
    logic [31:0] exp_q[$];
    bit          pending_done;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .Address(Address), .Write_Data(Write_Data),
        .Read_Data(Read_Data), .Stall(Stall), .Misaligned(Misaligned),
        .Bus_Error(Bus_Error), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // reference model
    function automatic int access_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] f3);
        logic [31:0] v;
        int          lane;
        lane = int'(a & 32'd3);
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (w >> (8 * lane)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (w >> (16 * (lane / 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // driver tasks
    task automatic run_txn(input bit mr, input bit mw, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdata, input int delay);
        int          size, exp_acc, stall_cnt, acc_cnt;
        bit          mis, tmo, done;
        logic [31:0] exp_be, exp_wd;
        size    = access_size(f3);
        mis     = (addr & 32'(size - 1)) != 0;
        tmo     = !mis && (delay >= TIMEOUT);
        exp_acc = mis ? 0 : (tmo ? TIMEOUT : delay + 1);
        exp_be  = mr ? 32'd0 : (32'((1 << size) - 1) << (addr & 32'd3));
        if (size == 1)      exp_wd = (wd & 32'hFF) * 32'h0101_0101;
        else if (size == 2) exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
        else                exp_wd = wd;
        if (mr) model_rd = (mis || tmo) ? 32'd0 : ref_load(rdata, addr, f3);
        exp_q.push_back(model_rd);

        MemRead = mr; MemWrite = mw; Funct3 = f3; Address = addr; Write_Data = wd;
        if (pending_done) @(negedge clk);
        mem_ready = 1'b0;
        stall_cnt = 0; acc_cnt = 0; done = 1'b0;
        for (int c = 0; c < TIMEOUT + 40 && !done; c++) begin
            #1;
            if (c == 0) begin
                check("idle_misaligned_clear", Misaligned, 0);
                check("idle_bus_error_clear", Bus_Error, 0);
                check("idle_no_req", mem_req, 0);
            end
            if (Stall) begin
                stall_cnt++;
                if (mem_req) begin
                    check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                    check("mem_we", mem_we, !mr);
                    check("mem_be", mem_be, exp_be);
                    if (!mr) check("mem_wdata", mem_wdata, exp_wd);
                    mem_ready = (acc_cnt == delay);
                    mem_rdata = mem_ready ? rdata : $urandom();
                    acc_cnt++;
                end
                @(negedge clk);
            end else begin
                done = 1'b1;
                check("done_state", dbg_state, 2);
                check("done_no_req", mem_req, 0);
                check("misaligned", Misaligned, mis);
                check("bus_error", Bus_Error, tmo);
                check("stall_cycles", stall_cnt, exp_acc + 1);
                check("access_cycles", acc_cnt, exp_acc);
                check("read_data", Read_Data, exp_q.pop_front());
            end
        end
        mem_ready = 1'b0;
        if (!done) begin
            check("txn_completes", 0, 1);
            void'(exp_q.pop_front());
        end
        pending_done = 1'b1;
    endtask

    task automatic idle(input int n);
        MemRead = 1'b0; MemWrite = 1'b0;
        if (pending_done) @(negedge clk);
        pending_done = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            check("idle_stall", Stall, 0);
            check("idle_req", mem_req, 0);
            check("idle_misaligned", Misaligned, 0);
            check("idle_bus_error", Bus_Error, 0);
            check("idle_read_hold", Read_Data, model_rd);
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = '0;
        Address = '0; Write_Data = '0; mem_ready = 1'b0; mem_rdata = '0;
        model_rd = '0; pending_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_read_data", Read_Data, 0);
        check("rst_stall", Stall, 0);
        check("rst_misaligned", Misaligned, 0);
        check("rst_bus_error", Bus_Error, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;
        @(negedge clk);

        // LB / LBU from a sign-bit byte lane
        run_txn(1, 0, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 0);
        check("lb_value", Read_Data, 32'hFFFF_FF80);
        run_txn(1, 0, 3'd4, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 0);
        check("lbu_value", Read_Data, 32'h0000_0080);
        idle(1);
        // SH upper half leaves Read_Data alone
        run_txn(0, 1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0);
        check("sh_read_hold", Read_Data, 32'h0000_0080);
        idle(1);
        // misaligned LW, then one idle cycle proves the pulse is one cycle wide
        run_txn(1, 0, 3'd2, 32'h0000_3001, 32'h0, 32'h5555_5555, 0);
        check("mis_read_zero", Read_Data, 32'h0);
        idle(1);
        // delayed ready, then no ready at all
        run_txn(1, 0, 3'd2, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 3);
        check("lw_delayed_value", Read_Data, 32'hDEAD_BEEF);
        run_txn(1, 0, 3'd2, 32'h0000_4004, 32'h0, 32'h1111_1111, 99);
        idle(1);
        // back-to-back SW then LW
        run_txn(0, 1, 3'd2, 32'h0000_5000, 32'hCAFE_F00D, 32'h0, 1);
        run_txn(1, 0, 3'd5, 32'h0000_5002, 32'h0, 32'h8765_4321, 0);
        check("lhu_value", Read_Data, 32'h0000_8765);
        idle(1);

        // reset while ACCESS waits on a ready that never comes
        MemRead = 1'b1; Funct3 = 3'd2; Address = 32'h0000_6000; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_req", mem_req, 1);
        reset = 1'b1; MemRead = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_stall", Stall, 0);
        check("mid_rst_read_data", Read_Data, 0);
        check("mid_rst_state", dbg_state, 0);
        reset = 1'b0;
        model_rd = '0;
        @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            bit          mr, mw;
            logic [2:0]  f3;
            logic [31:0] a;
            int          d;
            mr = 1'($urandom_range(0, 1));
            mw = mr ? 1'($urandom_range(0, 1)) : 1'b1;
            f3 = mr ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            a  = $urandom();
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            d  = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 5));
            run_txn(mr, mw, f3, a, $urandom(), $urandom(), d);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
